// File: rtl/fir_core_sequencer.sv
// Round-robin two-channel front end for the fir_filter_core sample queue; tags each result with its source.
// Define FIR_SEQ_STATS_EN to add the wr_count/res_count statistics outputs.
module fir_core_sequencer #(
  parameter int DATA_W    = 16,
  parameter int SUM_W     = 32,
  parameter int TAG_DEPTH = 8
) (
  input  logic              clk3,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              core_write,
  output logic [DATA_W-1:0] core_data,
  output logic              core_read,
  input  logic              core_full,
  input  logic              core_empty,
  input  logic [SUM_W-1:0]  core_sum,
  output logic              res_valid,
  output logic              res_chan,
  output logic [SUM_W-1:0]  res_sum,
  output logic              busy,
`ifdef FIR_SEQ_STATS_EN
  output logic [15:0]       wr_count,
  output logic [15:0]       res_count,
`endif
  output logic              err_orphan
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WR, RD, CAP} state_t;

  state_t               state, state_nxt;
  logic                 rr_ptr;
  logic                 wr_chan;
  logic [CNT_W-1:0]     tag_cnt, tag_cnt_nxt;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [TAG_DEPTH-1:0] tag_mem;
  logic                 read_pend, write_ok, grant_any, grant_chan, orphan_hit;

  // Reads outrank writes so results never back up inside the core.
  always_comb begin
    read_pend   = !core_empty && (tag_cnt != '0);
    orphan_hit  = (state == IDLE) && !core_empty && (tag_cnt == '0);
    write_ok    = !read_pend && !core_full && (tag_cnt != CNT_W'(TAG_DEPTH));
    grant_any   = req0_valid || req1_valid;
    grant_chan  = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    state_nxt   = state;
    tag_cnt_nxt = tag_cnt;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (read_pend) begin
          state_nxt = RD;
        end else if (grant_any && write_ok) begin
          state_nxt  = WR;
          req0_ready = reset && !grant_chan;
          req1_ready = reset && grant_chan;
        end
      end
      WR: begin
        state_nxt   = IDLE;
        tag_cnt_nxt = tag_cnt + CNT_W'(1);
      end
      RD:  state_nxt = CAP;
      CAP: begin
        state_nxt   = IDLE;
        tag_cnt_nxt = tag_cnt - CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      wr_chan    <= 1'b0;
      tag_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_mem    <= '0;
      core_write <= 1'b0;
      core_read  <= 1'b0;
      core_data  <= '0;
      res_valid  <= 1'b0;
      res_chan   <= 1'b0;
      res_sum    <= '0;
      busy       <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      state      <= state_nxt;
      tag_cnt    <= tag_cnt_nxt;
      core_write <= (state_nxt == WR);
      core_read  <= (state_nxt == RD);
      res_valid  <= (state == CAP);
      busy       <= (state_nxt != IDLE) || (tag_cnt_nxt != '0);
      if (orphan_hit) begin
        err_orphan <= 1'b1;
      end
      // core_data doubles as the latched sample register.
      if (state == IDLE && state_nxt == WR) begin
        core_data <= grant_chan ? req1_data : req0_data;
        wr_chan   <= grant_chan;
        rr_ptr    <= !grant_chan;
      end
      if (state == WR) begin
        tag_mem[wr_ptr] <= wr_chan;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (state == CAP) begin
        res_sum  <= core_sum;
        res_chan <= tag_mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_W'(1);
      end
    end
  end

`ifdef FIR_SEQ_STATS_EN
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      wr_count  <= '0;
      res_count <= '0;
    end else begin
      if (state == WR)  wr_count  <= wr_count + 16'd1;
      if (state == CAP) res_count <= res_count + 16'd1;
    end
  end
`endif

endmodule
